// File: rtl/fetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: ITIM request/response
// records, the FIFO entry layout and the controller state encoding.
package fetch_buffer_wires;

  localparam int fb_depth_default = 4;
  localparam int fb_ptr_width     = $clog2(fb_depth_default);

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fb_entry_type;

  typedef enum logic [1:0] {
    st_idle       = 2'd0,
    st_wait       = 2'd1,
    st_wait_fence = 2'd2
  } fb_state_type;

  // Instruction fetch addresses are always word aligned.
  function automatic logic [31:0] fb_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Small circular buffer of {pc, data} words between the fetch controller
// and decode. Flush empties it in one cycle; the head reads as zero when
// the buffer is empty.
module fetch_buffer_fifo
  import fetch_buffer_wires::*;
#(
  parameter int depth = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  fb_entry_type              push_entry,
  input  logic                      pop,
  output fb_entry_type              head,
  output logic [$clog2(depth):0]    count
);

  localparam int ptr_w = $clog2(depth);
  localparam logic [ptr_w:0] depth_c = (ptr_w + 1)'(depth);

  fb_entry_type     entries [depth];
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop on empty is ignored; a push into a full buffer is dropped.
  always_comb begin
    do_push = push && (count != depth_c);
    do_pop  = pop && (count != '0);
  end

  // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge clock) begin
    if (do_push && !flush) entries[wr_ptr] <= push_entry;
  end

  // Head entry presented combinationally, zero when empty.
  always_comb begin
    head = (count != '0) ? entries[rd_ptr] : '0;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch stage in front of the ITIM. Keeps one request in
// flight, buffers returned words with their PC and handles redirects and
// fence.i by flushing and discarding the stale response.
//
//   state          | meaning
//   ---------------+----------------------------------------------------
//   st_idle        | nothing outstanding; issue when space or fence pending
//   st_wait        | fetch request outstanding; push (or drop) on ready
//   st_wait_fence  | fence request outstanding; response data discarded
module fetch_buffer
  import fetch_buffer_wires::*;
#(
  parameter int          fb_depth      = fb_depth_default,
  parameter logic [31:0] fb_start_addr = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        redirect_fence,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output mem_in_type  itim_in,
  input  mem_out_type itim_out
);

  localparam int ptr_w = $clog2(fb_depth);
  localparam logic [ptr_w:0] depth_c = (ptr_w + 1)'(fb_depth);

  typedef struct packed {
    fb_state_type state;
    logic [31:0]  pc;
    logic         drop;
    logic         pend_fence;
  } reg_type;

  localparam reg_type init_reg = '{
    state:      st_idle,
    pc:         fb_start_addr,
    drop:       1'b0,
    pend_fence: 1'b0
  };

  reg_type r, rin;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_pop_eff;
  fb_entry_type   fifo_push_entry;
  fb_entry_type   fifo_head;
  logic [ptr_w:0] fifo_count;
  logic [ptr_w:0] count_nx;
  logic           done;
  logic           space_ok;
  logic           issue;
  logic           issue_fence;

  fetch_buffer_fifo #(.depth(fb_depth)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (fifo_push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Next-state, FIFO control and the single-cycle ITIM request pulse.
  always_comb begin
    reg_type v;
    v               = r;
    done            = 1'b0;
    fifo_push       = 1'b0;
    fifo_push_entry = '{pc: r.pc, data: itim_out.mem_rdata};
    issue           = 1'b0;
    issue_fence     = 1'b0;

    // A redirect flushes the buffer, so a pop in the same cycle is moot.
    fifo_pop     = instr_ready && (fifo_count != '0) && !redirect_valid;
    fifo_pop_eff = fifo_pop;

    if ((r.state != st_idle) && itim_out.mem_ready) begin
      done = 1'b1;
      if (r.drop) begin
        v.drop = 1'b0;
      end else if (r.state == st_wait_fence) begin
        v.pend_fence = 1'b0;
      end else if (!redirect_valid) begin
        fifo_push = 1'b1;
        v.pc      = r.pc + 32'd4;
      end
    end

    // Redirect wins; an outstanding request whose response has not yet
    // arrived is marked so its data is thrown away when it does.
    if (redirect_valid) begin
      v.pc         = fb_align(redirect_addr);
      v.pend_fence = redirect_fence;
      if ((r.state != st_idle) && !itim_out.mem_ready) v.drop = 1'b1;
    end

    count_nx = redirect_valid ? '0
             : fifo_count + (ptr_w + 1)'(fifo_push) - (ptr_w + 1)'(fifo_pop_eff);

    // From a settled idle state only the current occupancy matters; after a
    // completion the push of this cycle must be counted as well.
    if ((r.state == st_idle) && !redirect_valid) space_ok = fifo_count < depth_c;
    else                                         space_ok = count_nx < depth_c;

    if (((r.state == st_idle) || done) && reset) begin
      v.state = st_idle;
      if (v.pend_fence) begin
        issue       = 1'b1;
        issue_fence = 1'b1;
        v.state     = st_wait_fence;
      end else if (space_ok) begin
        issue   = 1'b1;
        v.state = st_wait;
      end
    end

    itim_in           = '0;
    itim_in.mem_instr = 1'b1;
    if (issue) begin
      itim_in.mem_valid = 1'b1;
      itim_in.mem_fence = issue_fence;
      itim_in.mem_addr  = v.pc;
    end

    rin = v;
  end

  // Controller register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) r <= init_reg;
    else        r <= rin;
  end

  // Decode-side view of the buffer head.
  always_comb begin
    instr_valid = (fifo_count != '0);
    instr_data  = fifo_head.data;
    instr_pc    = fifo_head.pc;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a behavioural ITIM of adjustable latency.
module tb_fetch_buffer;
  import fetch_buffer_wires::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        redirect_fence;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  mem_in_type  itim_in;
  mem_out_type itim_out;

  int tests = 0;
  int fails = 0;
  int lat = 1;
  int field_err = 0;
  int full_err = 0;

  logic [31:0] req_addr[$];
  logic [31:0] req_fence[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_data[$];

  fetch_buffer #(.fb_depth(4), .fb_start_addr(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .redirect_fence (redirect_fence),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .itim_in        (itim_in),
    .itim_out       (itim_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // ITIM model: responds lat cycles after the request cycle.
  logic        busy;
  int          cnt;
  logic [31:0] m_addr;
  logic        m_fence;
  always @(posedge clock) begin
    itim_out.mem_ready <= 1'b0;
    itim_out.mem_rdata <= 32'h0;
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      if (busy) begin
        if (cnt <= 1) begin
          itim_out.mem_ready <= 1'b1;
          itim_out.mem_rdata <= m_fence ? 32'h0 : mem_word(m_addr);
          busy <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (itim_in.mem_valid) begin
        m_addr  <= itim_in.mem_addr;
        m_fence <= itim_in.mem_fence;
        if (lat <= 1) begin
          itim_out.mem_ready <= 1'b1;
          itim_out.mem_rdata <= itim_in.mem_fence ? 32'h0 : mem_word(itim_in.mem_addr);
          busy <= 1'b0;
        end else begin
          busy <= 1'b1;
          cnt  <= lat - 1;
        end
      end
    end
  end

  // Request/delivery logs plus protocol and overflow watchers.
  always @(posedge clock) begin
    if (reset) begin
      if (itim_in.mem_valid) begin
        req_addr.push_back(itim_in.mem_addr);
        req_fence.push_back({31'h0, itim_in.mem_fence});
        if (itim_in.mem_instr !== 1'b1 || itim_in.mem_spec !== 1'b0 ||
            itim_in.mem_wdata !== 32'h0 || itim_in.mem_wstrb !== 4'h0)
          field_err++;
      end else if (itim_in.mem_addr !== 32'h0 || itim_in.mem_fence !== 1'b0) begin
        field_err++;
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        del_pc.push_back(instr_pc);
        del_data.push_back(instr_data);
      end
      if (dut.fifo_push && int'(dut.fifo_count) == 4) full_err++;
    end
  end

  function automatic logic [31:0] g_ra(input int i);
    return (i < req_addr.size()) ? req_addr[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] g_rf(input int i);
    return (i < req_fence.size()) ? req_fence[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] g_dp(input int i);
    return (i < del_pc.size()) ? del_pc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] g_dd(input int i);
    return (i < del_data.size()) ? del_data[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    req_addr.delete();
    req_fence.delete();
    del_pc.delete();
    del_data.delete();
  endtask

  task automatic wait_req(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && req_addr.size() < n; i++) @(negedge clock);
    chk(tag, 32'(req_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_del(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && del_pc.size() < n; i++) @(negedge clock);
    chk(tag, 32'(del_pc.size() >= n), 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] addr, input logic fence);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    redirect_fence = fence;
    @(negedge clock);
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    redirect_fence = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    clear_logs();
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    redirect_fence = 1'b0;
    instr_ready    = 1'b1;

    // Reset state and in-order delivery with 1-cycle hits.
    repeat (3) @(negedge clock);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_mem_valid", {31'h0, itim_in.mem_valid}, 32'h0);
    clear_logs();
    reset = 1'b1;
    wait_del(4, 40, "seq_timeout");
    chk("seq_req0", g_ra(0), 32'h0);
    chk("seq_pc0", g_dp(0), 32'h0);
    chk("seq_pc1", g_dp(1), 32'h4);
    chk("seq_pc2", g_dp(2), 32'h8);
    chk("seq_pc3", g_dp(3), 32'hC);
    chk("seq_data0", g_dd(0), 32'h5A5A5A5A);
    chk("seq_data1", g_dd(1), 32'h5A5A5A5E);
    chk("seq_data2", g_dd(2), 32'h5A5A5A52);
    chk("seq_data3", g_dd(3), 32'h5A5A5A56);

    // Backpressure: exactly four requests fill the buffer, then fetch stalls.
    instr_ready = 1'b0;
    apply_reset();
    repeat (20) @(negedge clock);
    chk("full_req_count", 32'(req_addr.size()), 32'd4);
    chk("full_req3", g_ra(3), 32'hC);
    chk("full_mem_valid", {31'h0, itim_in.mem_valid}, 32'h0);
    chk("full_head_valid", {31'h0, instr_valid}, 32'h1);
    chk("full_head_pc", instr_pc, 32'h0);
    chk("full_head_data", instr_data, 32'h5A5A5A5A);
    clear_logs();
    instr_ready = 1'b1;
    wait_req(1, 10, "resume_timeout");
    chk("resume_addr", g_ra(0), 32'h10);
    chk("resume_del0", g_dp(0), 32'h0);

    // Redirect while a 5-cycle miss is outstanding.
    lat = 5;
    apply_reset();
    repeat (3) @(negedge clock);
    clear_logs();
    pulse_redirect(32'h100, 1'b0);
    wait_del(1, 60, "miss_redir_timeout");
    chk("miss_redir_req", g_ra(0), 32'h100);
    chk("miss_redir_fence", g_rf(0), 32'h0);
    chk("miss_redir_pc", g_dp(0), 32'h100);
    chk("miss_redir_data", g_dd(0), 32'h5A5A5B5A);

    // Redirect with fence while back-to-back 1-cycle hits are streaming.
    lat = 1;
    apply_reset();
    repeat (6) @(negedge clock);
    clear_logs();
    pulse_redirect(32'h200, 1'b1);
    wait_req(2, 20, "fence_req_timeout");
    wait_del(1, 20, "fence_del_timeout");
    chk("fence_req0_fence", g_rf(0), 32'h1);
    chk("fence_req0_addr", g_ra(0), 32'h200);
    chk("fence_req1_fence", g_rf(1), 32'h0);
    chk("fence_req1_addr", g_ra(1), 32'h200);
    chk("fence_del_pc", g_dp(0), 32'h200);
    chk("fence_del_data", g_dd(0), 32'h5A5A585A);

    // Misaligned redirect target and 32-bit PC wrap.
    clear_logs();
    pulse_redirect(32'h103, 1'b0);
    wait_del(1, 20, "align_timeout");
    chk("align_req", g_ra(0), 32'h100);
    chk("align_pc", g_dp(0), 32'h100);
    clear_logs();
    pulse_redirect(32'hFFFF_FFFC, 1'b0);
    wait_del(2, 20, "wrap_timeout");
    chk("wrap_pc0", g_dp(0), 32'hFFFF_FFFC);
    chk("wrap_data0", g_dd(0), 32'hA5A5A5A6);
    chk("wrap_pc1", g_dp(1), 32'h0);
    chk("wrap_data1", g_dd(1), 32'h5A5A5A5A);

    // Reset while a request is outstanding and words are buffered.
    instr_ready = 1'b0;
    lat = 5;
    clear_logs();
    pulse_redirect(32'h300, 1'b0);
    for (int i = 0; i < 40 && !instr_valid; i++) @(negedge clock);
    chk("midrst_buffered_pc", instr_pc, 32'h300);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("midrst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    chk("midrst_mem_valid", {31'h0, itim_in.mem_valid}, 32'h0);
    clear_logs();
    reset = 1'b1;
    wait_req(1, 10, "midrst_req_timeout");
    chk("midrst_first_addr", g_ra(0), 32'h0);
    chk("midrst_first_fence", g_rf(0), 32'h0);

    chk("fixed_fields", 32'(field_err), 32'd0);
    chk("push_when_full", 32'(full_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
